// File: rtl/pam4_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : pam4_ber_checker
// Purpose  : PAM4 bit-error-rate checker. Slices decided DFE symbols and
//            training reference levels to Gray-coded 2-bit codes, aligns the
//            two streams through a reference FIFO, and once locked counts
//            compared symbols and symbol errors.
// Ports    : clk, rst (async, active-high)
//            sym_in/sym_in_valid   decided symbol level (SW bits, signed)
//            ref_in/ref_in_valid   training reference level (signed)
//            clear                 synchronous clear of counters/flags/FIFO
//            bits_out/_valid       Gray code of the last symbol, 1-cycle strobe
//            locked                alignment achieved
//            err_count/sym_count   saturating error / compare counters
//            ref_overflow/_underflow  sticky FIFO status flags
// Revision : 1.0  initial release
// ============================================================================
module pam4_ber_checker #(
  parameter int SIGNAL_RESOLUTION     = 8,
  parameter int PULSE_RESPONSE_LENGTH = 2,
  parameter int SYMBOL_SEPERATION     = 56,
  parameter int REF_DEPTH             = 16,
  parameter int LOCK_COUNT            = 8,
  parameter int LOSS_COUNT            = 4,
  parameter int COUNT_WIDTH           = 32
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic signed [SIGNAL_RESOLUTION*PULSE_RESPONSE_LENGTH-1:0] sym_in,
  input  logic                                                  sym_in_valid,
  input  logic signed [SIGNAL_RESOLUTION-1:0]                   ref_in,
  input  logic                                                  ref_in_valid,
  input  logic                                                  clear,
  output logic [1:0]                                            bits_out,
  output logic                                                  bits_out_valid,
  output logic                                                  locked,
  output logic [COUNT_WIDTH-1:0]                                err_count,
  output logic [COUNT_WIDTH-1:0]                                sym_count,
  output logic                                                  ref_overflow,
  output logic                                                  ref_underflow
);

  localparam int SW     = SIGNAL_RESOLUTION * PULSE_RESPONSE_LENGTH;
  localparam int AW     = (REF_DEPTH > 1) ? $clog2(REF_DEPTH) : 1;
  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int LOSS_W = $clog2(LOSS_COUNT + 1);
  localparam logic signed [SW-1:0] SEP_POS = SW'(SYMBOL_SEPERATION);
  localparam logic signed [SW-1:0] SEP_NEG = -SEP_POS;

  typedef enum logic [0:0] {SEARCH = 1'b0, LOCKED = 1'b1} state_t;

  // Gray slicer: 00 | 01 | 11 | 10 from most negative to most positive level
  function automatic logic [1:0] slice(input logic signed [SW-1:0] x);
    if (x < SEP_NEG)      return 2'b00;
    else if (x[SW-1])     return 2'b01;
    else if (x < SEP_POS) return 2'b11;
    else                  return 2'b10;
  endfunction

  state_t                 state_q, state_d;
  logic [RUN_W-1:0]       run_q, run_d;
  logic [LOSS_W-1:0]      err_run_q, err_run_d;
  logic [COUNT_WIDTH-1:0] err_count_q, err_count_d;
  logic [COUNT_WIDTH-1:0] sym_count_q, sym_count_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic [1:0]             bits_q, bits_d;
  logic                   bits_valid_q, bits_valid_d;
  logic                   locked_q, locked_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [AW:0]            level_q, level_d;
  logic [1:0]             mem_q [REF_DEPTH];

  logic signed [SW-1:0] ref_ext;
  logic [1:0]           sym_code;
  logic [1:0]           ref_code;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 match;
  logic                 do_cmp;
  logic                 pop;
  logic                 push;

  assign ref_ext    = SW'(ref_in);
  assign sym_code   = slice(sym_in);
  assign ref_code   = slice(ref_ext);
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == (AW+1)'(REF_DEPTH));
  assign match      = (sym_code == mem_q[rd_ptr_q]);
  assign do_cmp     = sym_in_valid && !fifo_empty && !clear;
  // SEARCH holds the head on a mismatch so the reference can slip one symbol
  assign pop        = do_cmp && ((state_q == LOCKED) || match);
  // A pop in the same cycle frees the slot, so a full FIFO may still accept
  assign push       = ref_in_valid && !clear && (!fifo_full || pop);

  always_comb begin
    state_d      = state_q;
    run_d        = run_q;
    err_run_d    = err_run_q;
    err_count_d  = err_count_q;
    sym_count_d  = sym_count_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    bits_valid_d = sym_in_valid;
    bits_d       = sym_in_valid ? sym_code : bits_q;

    if (clear) begin
      state_d     = SEARCH;
      run_d       = '0;
      err_run_d   = '0;
      err_count_d = '0;
      sym_count_d = '0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
    end else begin
      if (ref_in_valid && !push)     ovf_d = 1'b1;
      if (sym_in_valid && fifo_empty) unf_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);

      if (do_cmp) begin
        case (state_q)
          SEARCH: begin
            if (match) begin
              if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
                state_d   = LOCKED;
                run_d     = '0;
                err_run_d = '0;
              end else begin
                run_d = run_q + 1'b1;
              end
            end else begin
              run_d = '0;
            end
          end
          default: begin
            if (sym_count_q != '1) sym_count_d = sym_count_q + 1'b1;
            if (!match) begin
              if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
              if (err_run_q == LOSS_W'(LOSS_COUNT - 1)) begin
                state_d   = SEARCH;
                err_run_d = '0;
              end else begin
                err_run_d = err_run_q + 1'b1;
              end
            end else begin
              err_run_d = '0;
            end
          end
        endcase
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SEARCH;
      run_q        <= '0;
      err_run_q    <= '0;
      err_count_q  <= '0;
      sym_count_q  <= '0;
      ovf_q        <= 1'b0;
      unf_q        <= 1'b0;
      bits_q       <= 2'b00;
      bits_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      err_run_q    <= err_run_d;
      err_count_q  <= err_count_d;
      sym_count_q  <= sym_count_d;
      ovf_q        <= ovf_d;
      unf_q        <= unf_d;
      bits_q       <= bits_d;
      bits_valid_q <= bits_valid_d;
      locked_q     <= locked_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers and level
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ref_code;
  end

  assign bits_out       = bits_q;
  assign bits_out_valid = bits_valid_q;
  assign locked         = locked_q;
  assign err_count      = err_count_q;
  assign sym_count      = sym_count_q;
  assign ref_overflow   = ovf_q;
  assign ref_underflow  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_pam4_ber_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_pam4_ber_checker
// Purpose  : Directed, scoreboard-checked bench for pam4_ber_checker.
//            Counters are narrowed to 4 bits so saturation is reachable.
// Revision : 1.0  initial release
// ============================================================================
module tb_pam4_ber_checker;

  localparam int CW = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] sym_in = '0;
  logic               sym_in_valid = 1'b0;
  logic signed [7:0]  ref_in = '0;
  logic               ref_in_valid = 1'b0;
  logic               clear = 1'b0;
  logic [1:0]         bits_out;
  logic               bits_out_valid;
  logic               locked;
  logic [CW-1:0]      err_count;
  logic [CW-1:0]      sym_count;
  logic               ref_overflow;
  logic               ref_underflow;

  pam4_ber_checker #(.COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .sym_in(sym_in), .sym_in_valid(sym_in_valid),
    .ref_in(ref_in), .ref_in_valid(ref_in_valid),
    .clear(clear),
    .bits_out(bits_out), .bits_out_valid(bits_out_valid),
    .locked(locked), .err_count(err_count), .sym_count(sym_count),
    .ref_overflow(ref_overflow), .ref_underflow(ref_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    bits;
    logic          lk;
    logic [CW-1:0] err;
    logic [CW-1:0] sym;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every bits_out_valid strobe consumes one expected entry
  always @(negedge clk) begin
    if (bits_out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bits_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("bits_out",  int'(bits_out),  int'(e.bits));
        chk("locked",    int'(locked),    int'(e.lk));
        chk("err_count", int'(err_count), int'(e.err));
        chk("sym_count", int'(sym_count), int'(e.sym));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ref(input int lvl);
    ref_in       = 8'(lvl);
    ref_in_valid = 1'b1;
    tick();
    ref_in_valid = 1'b0;
  endtask

  task automatic push_n(input int lvl, input int n);
    for (int i = 0; i < n; i++) push_ref(lvl);
  endtask

  task automatic expect_out(input int b, input int lk, input int e, input int s);
    exp_t x;
    x.bits = 2'(b);
    x.lk   = 1'(lk);
    x.err  = CW'(e);
    x.sym  = CW'(s);
    exp_q.push_back(x);
  endtask

  task automatic send(input int lvl, input int b, input int lk, input int e, input int s);
    sym_in       = 16'(lvl);
    sym_in_valid = 1'b1;
    expect_out(b, lk, e, s);
    tick();
    sym_in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_err"},    int'(err_count),     0);
    chk({tag, "_sym"},    int'(sym_count),     0);
    chk({tag, "_locked"}, int'(locked),        0);
    chk({tag, "_ovf"},    int'(ref_overflow),  0);
    chk({tag, "_unf"},    int'(ref_underflow), 0);
  endtask

  int sat_err [20] = '{1,2,3,3, 4,5,6,6, 7,8,9,9, 10,11,12,12, 13,14,15,15};
  int sat_sym [20] = '{10,11,12,13, 14,15,15,15, 15,15,15,15, 15,15,15,15, 15,15,15,15};

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bits_out",       int'(bits_out),       0);
    chk("rst_bits_out_valid", int'(bits_out_valid), 0);
    chk_all_zero("rst");
    rst = 1'b0;

    // Level mapping incl. slicer boundaries; lock on the 8th match
    push_ref(-84); push_ref(-28); push_ref(28); push_ref(84);
    push_ref(-57); push_ref(-56); push_ref(-1); push_ref(0);
    push_ref(55);  push_ref(56);
    send(-84, 0, 0, 0, 0);
    send(-28, 1, 0, 0, 0);
    send(28,  3, 0, 0, 0);
    send(84,  2, 0, 0, 0);
    send(-57, 0, 0, 0, 0);
    send(-56, 1, 0, 0, 0);
    send(-1,  1, 0, 0, 0);
    send(0,   3, 1, 0, 0);
    send(55,  3, 1, 0, 1);
    send(56,  2, 1, 0, 2);
    chk("unf_before_empty", int'(ref_underflow), 0);
    send(300, 2, 1, 0, 2);
    chk("unf_after_empty", int'(ref_underflow), 1);

    // Loss of lock: 3 errors, 1 match, 4 errors
    push_n(84, 8);
    send(-84, 0, 1, 1, 3);
    send(-84, 0, 1, 2, 4);
    send(-84, 0, 1, 3, 5);
    send(84,  2, 1, 3, 6);
    send(-84, 0, 1, 4, 7);
    send(-84, 0, 1, 5, 8);
    send(-84, 0, 1, 6, 9);
    send(-84, 0, 0, 7, 10);
    chk("loss_locked", int'(locked), 0);

    // SEARCH mismatch holds the head and restarts the run
    push_n(28, 15);
    for (int i = 0; i < 7; i++) send(28, 3, 0, 7, 10);
    send(-28, 1, 0, 7, 10);
    for (int i = 0; i < 7; i++) send(28, 3, 0, 7, 10);
    send(28, 3, 1, 7, 10);

    // Overflow: 17th push dropped, FIFO keeps the first 16
    pulse_clear();
    chk_all_zero("clr1");
    push_n(28, 16);
    chk("ovf_at_full", int'(ref_overflow), 0);
    push_ref(-84);
    chk("ovf_dropped", int'(ref_overflow), 1);
    for (int i = 0; i < 7; i++) send(28, 3, 0, 0, 0);
    send(28, 3, 1, 0, 0);
    for (int i = 1; i <= 8; i++) send(28, 3, 1, 0, i);
    chk("ovf_unf_before", int'(ref_underflow), 0);
    send(28, 3, 1, 0, 8);
    chk("ovf_unf_after", int'(ref_underflow), 1);

    // Same-cycle push and pop while full
    pulse_clear();
    push_n(28, 16);
    ref_in = 8'(28); ref_in_valid = 1'b1;
    sym_in = 16'(28); sym_in_valid = 1'b1;
    expect_out(3, 0, 0, 0);
    tick();
    ref_in_valid = 1'b0; sym_in_valid = 1'b0;
    chk("pushpop_no_ovf", int'(ref_overflow), 0);
    for (int i = 0; i < 6; i++) send(28, 3, 0, 0, 0);
    send(28, 3, 1, 0, 0);
    for (int i = 1; i <= 9; i++) send(28, 3, 1, 0, i);
    chk("pushpop_unf_before", int'(ref_underflow), 0);
    send(28, 3, 1, 0, 9);
    chk("pushpop_unf_after", int'(ref_underflow), 1);

    // Saturation of both counters, then clear
    for (int g = 0; g < 5; g++) begin
      push_n(28, 4);
      for (int k = 0; k < 4; k++) begin
        if (k < 3) send(-28, 1, 1, sat_err[g*4+k], sat_sym[g*4+k]);
        else       send(28,  3, 1, sat_err[g*4+k], sat_sym[g*4+k]);
      end
    end
    push_ref(28);
    send(-28, 1, 1, 15, 15);
    push_n(28, 2);
    pulse_clear();
    chk_all_zero("clr2");
    send(28, 3, 0, 0, 0);
    chk("clr_flushed_fifo", int'(ref_underflow), 1);

    // Mid-stream reset discards FIFO and in-flight strobe
    pulse_clear();
    push_n(28, 3);
    sym_in = 16'(28); sym_in_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1; sym_in_valid = 1'b0;
    #1;
    chk("midrst_valid", int'(bits_out_valid), 0);
    chk("midrst_bits",  int'(bits_out),       0);
    chk_all_zero("midrst");
    tick();
    rst = 1'b0;
    push_ref(84);
    send(84, 2, 0, 0, 0);
    chk("post_rst_push", int'(ref_underflow), 0);
    send(84, 2, 0, 0, 0);
    chk("post_rst_flushed", int'(ref_underflow), 1);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
